iob_cache_perf_cnt: RTL and testbench

- Parametrised performance-counter bank for the cache. Replaces the fixed four-counter control block.
- Holds N_EVT independent event counters with selectable wrap or saturate mode, sticky per-channel overflow flags, a global enable, synchronous clear, and an atomic snapshot into shadow registers.
- Provides a registered indexed read port for software access through the cache CSR path.
- Sits beside the cache front-end and consumes one-cycle hit/miss strobes.

---
 rtl/iob_cache_perf_cnt.sv | 133 +++++++++++++
 tb/tb_iob_cache_perf_cnt.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_perf_cnt.sv
// ---------------------------------------------------------------------------
// iob_cache_perf_cnt
//
// Performance-counter bank for the cache. Each of N_EVT channels counts
// one-cycle event strobes from the cache front-end while the global enable
// is high. On overflow a channel either wraps to zero or holds at all-ones,
// depending on SATURATE, and sets its sticky overflow flag. A snapshot
// copies every live counter into a shadow register in one cycle. An indexed,
// registered read port gives software access to live or shadow values.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (highest priority)
//   en_i         counting enable
//   evt_i        per-channel event strobes (bit k -> channel k)
//   clear_i      zero live counters and overflow flags
//   snap_i       copy live counters into shadows (pre-increment, pre-clear)
//   rd_en_i      read request
//   rd_sel_i     channel index for the read
//   rd_shadow_i  read source: 0 = live, 1 = shadow
//   rdata_o      registered read data
//   rvalid_o     read-data valid strobe
//   ovf_o        sticky overflow flags
//   cnt_o        flat live counters, channel k at [k*CNT_W +: CNT_W]
//
// Read handshake: there is no backpressure. A request is taken in every
// cycle rd_en_i is high; exactly one cycle later rvalid_o is high for one
// cycle with rdata_o holding the selected value as it stood before the
// request edge. With rd_en_i low, rvalid_o is low and rdata_o holds.
// ---------------------------------------------------------------------------
module iob_cache_perf_cnt #(
  parameter int N_EVT    = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int SEL_W    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [N_EVT-1:0]       evt_i,
  input  logic                   clear_i,
  input  logic                   snap_i,
  input  logic                   rd_en_i,
  input  logic [SEL_W-1:0]       rd_sel_i,
  input  logic                   rd_shadow_i,
  output logic [CNT_W-1:0]       rdata_o,
  output logic                   rvalid_o,
  output logic [N_EVT-1:0]       ovf_o,
  output logic [N_EVT*CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt    [N_EVT];
  logic [CNT_W-1:0] r_shadow [N_EVT];
  logic [N_EVT-1:0] r_ovf;
  logic [CNT_W-1:0] r_rdata;
  logic             r_rvalid;

  logic [CNT_W-1:0] w_rd_data;

  // Read mux: a select with no matching channel falls through to zero, so
  // out-of-range indices return 0 without any array access past N_EVT.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < N_EVT; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        w_rd_data = rd_shadow_i ? r_shadow[k] : r_cnt[k];
      end
    end
  end

  // Live counters and overflow flags. Clear dominates a same-cycle event.
  // Overflow is detected by comparing against all-ones before the increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_EVT; k++) begin
        r_cnt[k] <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int k = 0; k < N_EVT; k++) begin
        if (clear_i) begin
          r_cnt[k] <= '0;
          r_ovf[k] <= 1'b0;
        end else if (en_i && evt_i[k]) begin
          if (r_cnt[k] == ALL_ONES) begin
            r_ovf[k] <= 1'b1;
            r_cnt[k] <= (SATURATE != 0) ? ALL_ONES : '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
        end
      end
    end
  end

  // Shadows sample the registered live values, so a snapshot sees the
  // pre-increment, pre-clear count. Clear leaves the shadows alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_EVT; k++) begin
        r_shadow[k] <= '0;
      end
    end else if (snap_i) begin
      for (int k = 0; k < N_EVT; k++) begin
        r_shadow[k] <= r_cnt[k];
      end
    end
  end

  // Registered read port; reset in the request cycle suppresses the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= rd_en_i;
      if (rd_en_i) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  for (genvar g = 0; g < N_EVT; g++) begin : g_cnt_out
    assign cnt_o[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_iob_cache_perf_cnt.sv
// ---------------------------------------------------------------------------
// tb_iob_cache_perf_cnt
//
// Two instances with CNT_W=8 share one set of inputs: u_wrap (SATURATE=0)
// and u_sat (SATURATE=1). Directed vectors with hand-computed results.
// Read responses are checked by a monitor against an expected queue.
// ---------------------------------------------------------------------------
module tb_iob_cache_perf_cnt;

  localparam int N_EVT = 4;
  localparam int CNT_W = 8;
  localparam int SEL_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             en;
  logic [N_EVT-1:0] evt;
  logic             clear;
  logic             snap;
  logic             rd_en;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_shadow;

  logic [CNT_W-1:0]       rdata_w, rdata_s;
  logic                   rvalid_w, rvalid_s;
  logic [N_EVT-1:0]       ovf_w, ovf_s;
  logic [N_EVT*CNT_W-1:0] cnt_w, cnt_s;

  iob_cache_perf_cnt #(.N_EVT(N_EVT), .CNT_W(CNT_W), .SATURATE(0), .SEL_W(SEL_W)) u_wrap (
    .clk_i(clk), .rst_i(rst), .en_i(en), .evt_i(evt), .clear_i(clear), .snap_i(snap),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_shadow_i(rd_shadow),
    .rdata_o(rdata_w), .rvalid_o(rvalid_w), .ovf_o(ovf_w), .cnt_o(cnt_w)
  );

  iob_cache_perf_cnt #(.N_EVT(N_EVT), .CNT_W(CNT_W), .SATURATE(1), .SEL_W(SEL_W)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .evt_i(evt), .clear_i(clear), .snap_i(snap),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_shadow_i(rd_shadow),
    .rdata_o(rdata_s), .rvalid_o(rvalid_s), .ovf_o(ovf_s), .cnt_o(cnt_s)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every rvalid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid_w || rvalid_s) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 64'(rvalid_w | rvalid_s), 64'd0);
      end else begin
        logic [CNT_W-1:0] e;
        e = exp_q.pop_front();
        check("rd_valid_wrap", 64'(rvalid_w), 64'd1);
        check("rd_valid_sat", 64'(rvalid_s), 64'd1);
        check("rd_data_wrap", 64'(rdata_w), 64'(e));
        check("rd_data_sat", 64'(rdata_s), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int sel, input logic shadow, input logic [CNT_W-1:0] exp);
    rd_en     = 1'b1;
    rd_sel    = SEL_W'(sel);
    rd_shadow = shadow;
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick();
    check("rd_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_evt(input logic [N_EVT-1:0] v, input int n);
    evt = v;
    repeat (n) tick();
    evt = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; evt = '0; clear = 1'b0; snap = 1'b0;
    rd_en = 1'b0; rd_sel = '0; rd_shadow = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();

    // Reset then idle
    check("rst_cnt_wrap", 64'(cnt_w), 64'd0);
    check("rst_cnt_sat", 64'(cnt_s), 64'd0);
    check("rst_ovf_wrap", 64'(ovf_w), 64'd0);
    check("rst_ovf_sat", 64'(ovf_s), 64'd0);
    check("rst_rvalid", 64'(rvalid_w | rvalid_s), 64'd0);
    check("rst_rdata", 64'(rdata_w | rdata_s), 64'd0);
    do_read(0, 1'b1, 8'd0);
    drain();

    // Independent counting: 5x all channels, 3x ch0 -> 8,5,5,5
    en = 1'b1;
    pulse_evt(4'b1111, 5);
    pulse_evt(4'b0001, 3);
    check("cnt_8555", 64'(cnt_w), 64'h05050508);
    en = 1'b0;
    pulse_evt(4'b1111, 4);
    check("cnt_hold_en0", 64'(cnt_w), 64'h05050508);
    check("cnt_hold_en0_sat", 64'(cnt_s), 64'h05050508);
    en = 1'b1;

    // Back-to-back live reads incl. out-of-range select
    do_read(0, 1'b0, 8'd8);
    do_read(1, 1'b0, 8'd5);
    do_read(2, 1'b0, 8'd5);
    do_read(3, 1'b0, 8'd5);
    do_read(5, 1'b0, 8'd0);
    drain();

    // Live read concurrent with an event returns the pre-increment value
    evt = 4'b0001;
    do_read(0, 1'b0, 8'd8);
    evt = '0;
    drain();
    check("cnt_after_rd_evt", 64'(cnt_w), 64'h05050509);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_cnt", 64'(cnt_w), 64'd0);

    // Overflow: 256 events on ch1
    pulse_evt(4'b0010, 256);
    check("wrap_cnt_256", 64'(cnt_w), 64'd0);
    check("wrap_ovf_256", 64'(ovf_w), 64'b0010);
    check("sat_cnt_256", 64'(cnt_s), 64'h0000FF00);
    check("sat_ovf_256", 64'(ovf_s), 64'b0010);
    pulse_evt(4'b0010, 44);
    check("wrap_cnt_300", 64'(cnt_w), 64'h00002C00);
    check("wrap_ovf_300", 64'(ovf_w), 64'b0010);
    check("sat_cnt_300", 64'(cnt_s), 64'h0000FF00);
    check("sat_ovf_300", 64'(ovf_s), 64'b0010);
    clear = 1'b1; tick(); clear = 1'b0;
    check("ovf_clear_cnt_wrap", 64'(cnt_w), 64'd0);
    check("ovf_clear_cnt_sat", 64'(cnt_s), 64'd0);
    check("ovf_clear_ovf_wrap", 64'(ovf_w), 64'd0);
    check("ovf_clear_ovf_sat", 64'(ovf_s), 64'd0);

    // ch2 at 7, then event + snap + clear in one cycle
    pulse_evt(4'b0100, 7);
    check("ch2_at_7", 64'(cnt_w), 64'h00070000);
    evt = 4'b0100; snap = 1'b1; clear = 1'b1;
    tick();
    evt = '0; snap = 1'b0; clear = 1'b0;
    check("snapclr_live_wrap", 64'(cnt_w), 64'd0);
    check("snapclr_live_sat", 64'(cnt_s), 64'd0);
    do_read(2, 1'b1, 8'd7);
    do_read(0, 1'b1, 8'd0);
    drain();
    // Clear must leave the shadows untouched
    pulse_evt(4'b0100, 3);
    clear = 1'b1; tick(); clear = 1'b0;
    do_read(2, 1'b1, 8'd7);
    drain();

    // Reset in the same cycle as a read request suppresses the response
    pulse_evt(4'b0001, 2);
    rd_en = 1'b1; rd_sel = '0; rd_shadow = 1'b0; rst = 1'b1;
    tick();
    rd_en = 1'b0; rst = 1'b0;
    check("rst_rd_rvalid_wrap", 64'(rvalid_w), 64'd0);
    check("rst_rd_rvalid_sat", 64'(rvalid_s), 64'd0);
    check("rst_rd_cnt", 64'(cnt_w), 64'd0);
    tick();
    check("rst_rd_rvalid_late", 64'(rvalid_w | rvalid_s), 64'd0);
    do_read(2, 1'b1, 8'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
